// File: rtl/cowboy_hit_detect.sv
// -----------------------------------------------------------------------------
// cowboy_hit_detect
//
// Purpose:
//   Once per video frame, checks whether the alien laser box overlaps the
//   cowboy hitbox. Each overlap that is counted costs the cowboy one life.
//   When the last life is lost, the sticky game-over flag GG is raised. The
//   laser, alien and cowboy motion blocks watch GG and freeze while it is set.
//   Only Reset clears GG.
//
// Optional feature (macro COWBOY_HIT_INVULN_EN):
//   Defined     : after a non-fatal hit the block enters a Cooldown state
//                 that lasts Invuln_Frames frames. Hits are ignored during
//                 Cooldown, and Hit_Flash blinks from bit 2 of the frame
//                 countdown.
//   Not defined : a non-fatal hit returns straight to Play. Only the re-arm
//                 flag limits repeat hits, and Hit_Flash is tied low.
//
// Ports:
//   Clk              in   50 MHz system clock
//   Reset            in   synchronous, active-high reset
//   frame_clk        in   ~60 Hz frame strobe (vs from the VGA controller)
//   LaserX, LaserY   in   [9:0] laser top-left corner, unsigned
//   CowboyX, CowboyY in   [9:0] cowboy top-left corner, unsigned
//   GG               out  game over, sticky until Reset
//   Lives            out  [2:0] remaining lives
//   HitPulse         out  one-Clk pulse per counted hit
//   Hit_Flash        out  sprite blink enable for the renderer
// -----------------------------------------------------------------------------
module cowboy_hit_detect #(
  parameter logic [9:0] LaserW        = 10'd4,
  parameter logic [9:0] LaserH        = 10'd8,
  parameter logic [9:0] CowboyW       = 10'd32,
  parameter logic [9:0] CowboyH       = 10'd48,
  parameter logic [9:0] Screen_Y_Max  = 10'd480,
  parameter logic [2:0] Lives_Init    = 3'd3,
  parameter logic [7:0] Invuln_Frames = 8'd60
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic [9:0] LaserX,
  input  logic [9:0] LaserY,
  input  logic [9:0] CowboyX,
  input  logic [9:0] CowboyY,
  output logic       GG,
  output logic [2:0] Lives,
  output logic       HitPulse,
  output logic       Hit_Flash
);

  typedef enum logic [1:0] {
    ST_PLAY     = 2'd0,
    ST_COOLDOWN = 2'd1,
    ST_DEAD     = 2'd2
  } state_t;

  // Frame strobe edge detection. Game logic advances only when
  // frame_clk_rising_edge_q is high.
  logic frame_clk_delayed_q;
  logic frame_clk_rising_edge_q;

  // Game state registers and their next-state values.
  state_t     state_q,     state_d;
  logic [2:0] lives_q,     lives_d;
  logic       armed_q,     armed_d;
  logic       gg_q,        gg_d;
  logic       hit_pulse_q, hit_pulse_d;
  logic       hit_flash_q, hit_flash_d;
  logic       hit_counted;

`ifdef COWBOY_HIT_INVULN_EN
  logic [7:0] icount_q, icount_d;
`else
  // Without the invulnerability window the frame count has no consumer.
  // Reducing it here keeps that explicit.
  logic unused_invuln_frames;
  assign unused_invuln_frames = ^Invuln_Frames;
`endif

  // ---------------------------------------------------------------------------
  // Overlap test.
  // Every operand is zero-extended to 11 bits, so X+W and Y+H near the
  // 1023 limit cannot wrap and cause a false negative. All comparisons are
  // strict, so boxes whose edges only touch do not overlap.
  // ---------------------------------------------------------------------------
  logic [10:0] laser_x_w, laser_y_w, cowboy_x_w, cowboy_y_w;
  logic [10:0] laser_x_end, laser_y_end, cowboy_x_end, cowboy_y_end;
  logic        laser_on_screen;
  logic        overlap;

  assign laser_x_w    = {1'b0, LaserX};
  assign laser_y_w    = {1'b0, LaserY};
  assign cowboy_x_w   = {1'b0, CowboyX};
  assign cowboy_y_w   = {1'b0, CowboyY};
  assign laser_x_end  = laser_x_w  + {1'b0, LaserW};
  assign laser_y_end  = laser_y_w  + {1'b0, LaserH};
  assign cowboy_x_end = cowboy_x_w + {1'b0, CowboyW};
  assign cowboy_y_end = cowboy_y_w + {1'b0, CowboyH};

  assign laser_on_screen = laser_y_w < {1'b0, Screen_Y_Max};

  assign overlap = laser_on_screen
                 && (laser_x_w  < cowboy_x_end) && (cowboy_x_w < laser_x_end)
                 && (laser_y_w  < cowboy_y_end) && (cowboy_y_w < laser_y_end);

  // ---------------------------------------------------------------------------
  // Next-state logic. Nothing changes except on a frame edge, and
  // HitPulse drops back to 0 on every other cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    lives_d     = lives_q;
    armed_d     = armed_q;
    gg_d        = gg_q;
    hit_pulse_d = 1'b0;
    hit_counted = 1'b0;
`ifdef COWBOY_HIT_INVULN_EN
    icount_d    = icount_q;
`endif

    if (frame_clk_rising_edge_q) begin
      unique case (state_q)
        ST_PLAY: begin
          if (overlap && armed_q) begin
            hit_counted = 1'b1;
            hit_pulse_d = 1'b1;
            lives_d     = (lives_q == 3'd0) ? 3'd0 : lives_q - 3'd1;
            if (lives_q <= 3'd1) begin
              state_d = ST_DEAD;
              gg_d    = 1'b1;
            end else begin
`ifdef COWBOY_HIT_INVULN_EN
              state_d  = ST_COOLDOWN;
              icount_d = Invuln_Frames;
`else
              state_d  = ST_PLAY;
`endif
            end
          end
        end

        ST_COOLDOWN: begin
`ifdef COWBOY_HIT_INVULN_EN
          // The count is at most 1 on the last Cooldown frame. With a
          // zero-length window the count starts at 0, so Cooldown still
          // lasts one frame and the count never wraps.
          icount_d = (icount_q == 8'd0) ? 8'd0 : icount_q - 8'd1;
          if (icount_q <= 8'd1) begin
            state_d = ST_PLAY;
          end
`else
          state_d = ST_PLAY;
`endif
        end

        ST_DEAD: begin
          lives_d = 3'd0;
          gg_d    = 1'b1;
        end

        default: begin
          state_d = ST_PLAY;
        end
      endcase

      // Re-arm: a counted hit disarms. The first clear frame re-arms, and
      // that happens in every state, including Cooldown.
      if (hit_counted) begin
        armed_d = 1'b0;
      end else if (!overlap) begin
        armed_d = 1'b1;
      end
    end

    // The blink is decoded from next-state values, so the registered
    // flash lines up with the state/Icount registers.
`ifdef COWBOY_HIT_INVULN_EN
    hit_flash_d = (state_d == ST_COOLDOWN) && icount_d[2];
`else
    hit_flash_d = 1'b0;
`endif
  end

  // ---------------------------------------------------------------------------
  // State registers. Reset takes priority over a coincident frame edge.
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk) begin
    if (Reset) begin
      frame_clk_delayed_q     <= 1'b0;
      frame_clk_rising_edge_q <= 1'b0;
      state_q                 <= ST_PLAY;
      lives_q                 <= Lives_Init;
      armed_q                 <= 1'b1;
      gg_q                    <= 1'b0;
      hit_pulse_q             <= 1'b0;
      hit_flash_q             <= 1'b0;
`ifdef COWBOY_HIT_INVULN_EN
      icount_q                <= 8'd0;
`endif
    end else begin
      frame_clk_delayed_q     <= frame_clk;
      frame_clk_rising_edge_q <= frame_clk & ~frame_clk_delayed_q;
      state_q                 <= state_d;
      lives_q                 <= lives_d;
      armed_q                 <= armed_d;
      gg_q                    <= gg_d;
      hit_pulse_q             <= hit_pulse_d;
      hit_flash_q             <= hit_flash_d;
`ifdef COWBOY_HIT_INVULN_EN
      icount_q                <= icount_d;
`endif
    end
  end

  assign GG        = gg_q;
  assign Lives     = lives_q;
  assign HitPulse  = hit_pulse_q;
  assign Hit_Flash = hit_flash_q;

endmodule

// File: tb/tb_cowboy_hit_detect.sv
// -----------------------------------------------------------------------------
// tb_cowboy_hit_detect
//
// Drives cowboy_hit_detect with directed scenarios and then randomized
// scenarios. The expected values come from a frame-level model: lives, an
// armed flag and a frame countdown for invulnerability. The bench is built
// with the same COWBOY_HIT_INVULN_EN setting as the design.
// -----------------------------------------------------------------------------
module tb_cowboy_hit_detect;

  localparam int LW = 4, LH = 8, CW = 32, CH = 48, SYM = 480;
  localparam int LIVES0 = 3;
  localparam int INV    = 4;
`ifdef COWBOY_HIT_INVULN_EN
  localparam bit INV_EN = 1'b1;
`else
  localparam bit INV_EN = 1'b0;
`endif

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       frame_clk = 1'b0;
  logic [9:0] LaserX = '0, LaserY = '0, CowboyX = '0, CowboyY = '0;
  logic       GG;
  logic [2:0] Lives;
  logic       HitPulse;
  logic       Hit_Flash;

  cowboy_hit_detect #(
    .Invuln_Frames(8'd4)
  ) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .frame_clk(frame_clk),
    .LaserX   (LaserX),
    .LaserY   (LaserY),
    .CowboyX  (CowboyX),
    .CowboyY  (CowboyY),
    .GG       (GG),
    .Lives    (Lives),
    .HitPulse (HitPulse),
    .Hit_Flash(Hit_Flash)
  );

  always #5 Clk = ~Clk;

  int total = 0;
  int bad   = 0;

  // Frame-level reference state.
  int m_lives;
  bit m_dead;
  bit m_armed;
  int m_cool;   // invulnerable frames still to run
  bit e_pulse;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic bit model_overlap(input int lx, input int ly, input int cx, input int cy);
    return (ly < SYM) && (lx < cx + CW) && (cx < lx + LW) && (ly < cy + CH) && (cy < ly + LH);
  endfunction

  function automatic bit model_flash();
    return INV_EN && (m_cool > 0) && (((m_cool >> 2) & 1) == 1);
  endfunction

  task automatic model_reset();
    m_lives = LIVES0;
    m_dead  = 1'b0;
    m_armed = 1'b1;
    m_cool  = 0;
  endtask

  task automatic model_frame(input bit ov);
    e_pulse = 1'b0;
    if (!m_dead) begin
      if (m_cool > 0) begin
        m_cool--;
      end else if (ov && m_armed) begin
        e_pulse = 1'b1;
        m_lives--;
        if (m_lives == 0) m_dead = 1'b1;
        else m_cool = INV_EN ? ((INV == 0) ? 1 : INV) : 0;
      end
    end
    if (e_pulse) m_armed = 1'b0;
    else if (!ov) m_armed = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Reset = 1'b1;
    frame_clk = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    Reset = 1'b0;
    model_reset();
    check("rst_lives", 32'(Lives), 32'(LIVES0));
    check("rst_gg", 32'(GG), 0);
    check("rst_pulse", 32'(HitPulse), 0);
    check("rst_flash", 32'(Hit_Flash), 0);
  endtask

  // One frame edge with the given positions, checked at n+1, n+2 and n+3.
  task automatic do_frame(input int lx, input int ly, input int cx, input int cy);
    @(negedge Clk);
    LaserX = 10'(lx); LaserY = 10'(ly); CowboyX = 10'(cx); CowboyY = 10'(cy);
    frame_clk = 1'b1;
    model_frame(model_overlap(lx, ly, cx, cy));
    @(posedge Clk); #1;              // cycle n+1
    frame_clk = 1'b0;
    check("pulse_n1", 32'(HitPulse), 0);
    @(posedge Clk); #1;              // cycle n+2
    check("pulse_n2", 32'(HitPulse), 32'(e_pulse));
    check("lives", 32'(Lives), 32'(m_lives));
    check("gg", 32'(GG), 32'(m_dead));
    check("flash", 32'(Hit_Flash), 32'(model_flash()));
    $display("frame L=(%0d,%0d) C=(%0d,%0d) pulse=%0d lives=%0d gg=%0d flash=%0d",
             lx, ly, cx, cy, HitPulse, Lives, GG, Hit_Flash);
    @(posedge Clk); #1;              // cycle n+3
    check("pulse_n3", 32'(HitPulse), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cx, cy, lx, ly, mode;
    model_reset();

    // Reset defaults
    do_reset();

    // Single hit, then hold the overlap for 5 more frames
    do_frame(100, 200, 90, 190);
    check("single_hit_lives", 32'(Lives), 2);
    repeat (5) do_frame(100, 200, 90, 190);
    check("hold_lives", 32'(Lives), 2);

    // Touching edge, parked laser and the 11-bit sum near 1023
    do_reset();
    do_frame(122, 200, 90, 190);
    check("touch_no_hit", 32'(Lives), 3);
    do_frame(100, 500, 90, 190);
    check("parked_no_hit", 32'(Lives), 3);
    do_frame(1020, 200, 1000, 190);
    check("wide_math_hit", 32'(Lives), 2);

    // Invulnerability window: away for 1 frame, back on frames 2-3, hit on the 5th
    do_reset();
    do_frame(100, 200, 90, 190);
    do_frame(300, 200, 90, 190);
    do_frame(100, 200, 90, 190);
    do_frame(100, 200, 90, 190);
    do_frame(300, 200, 90, 190);
    do_frame(100, 200, 90, 190);
    if (INV_EN) check("invuln_5th_hit", 32'(Lives), 1);

    // Game over after three separated hits, then stays dead until Reset
    do_reset();
    repeat (3) begin
      do_frame(100, 200, 90, 190);
      repeat (5) do_frame(300, 200, 90, 190);
    end
    check("dead_lives", 32'(Lives), 0);
    check("dead_gg", 32'(GG), 1);
    repeat (3) do_frame(100, 200, 90, 190);
    check("dead_hold_gg", 32'(GG), 1);
    do_reset();

    // Reset coincides with the frame-edge cycle while overlapping
    @(negedge Clk);
    LaserX = 10'd100; LaserY = 10'd200; CowboyX = 10'd90; CowboyY = 10'd190;
    frame_clk = 1'b1;
    @(posedge Clk); #1;
    frame_clk = 1'b0;
    Reset = 1'b1;
    @(posedge Clk); #1;
    Reset = 1'b0;
    model_reset();
    check("rprio_pulse", 32'(HitPulse), 0);
    check("rprio_lives", 32'(Lives), 32'(LIVES0));
    @(posedge Clk); #1;
    check("rprio_pulse_after", 32'(HitPulse), 0);
    check("rprio_lives_after", 32'(Lives), 32'(LIVES0));

    // Randomized frames
    for (int i = 0; i < 160; i++) begin
      if (m_dead && ($urandom % 3 == 0)) do_reset();
      cx = $urandom_range(0, 990);
      cy = $urandom_range(0, 430);
      mode = $urandom % 4;
      if (mode == 0) begin
        lx = $urandom_range(0, 1023);
        ly = $urandom_range(0, 1023);
      end else begin
        lx = cx + $urandom_range(0, 44) - 8;
        ly = cy + $urandom_range(0, 64) - 12;
        if (mode == 3 && ($urandom % 2 == 0)) ly = $urandom_range(470, 520);
      end
      if (lx < 0) lx = 0;
      if (lx > 1023) lx = 1023;
      if (ly < 0) ly = 0;
      if (ly > 1023) ly = 1023;
      do_frame(lx, ly, cx, cy);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cowboy_hit_detect.md
# cowboy_hit_detect

Consumes the alien laser position (`LaserX`/`LaserY`) and the cowboy sprite position once per frame. It detects laser/cowboy overlap, decrements the cowboy's lives, and raises the sticky game-over flag `GG`. `GG` fans back into the laser, alien and cowboy motion blocks, which freeze on it. It sits directly downstream of the alien laser block and closes the game-over loop.

## Interface
- `LaserW`, 10'd4: laser box width (px)
- `LaserH`, 10'd8: laser box height (px)
- `CowboyW`, 10'd32: cowboy hitbox width (px)
- `CowboyH`, 10'd48: cowboy hitbox height (px)
- `Screen_Y_Max`, 10'd480: laser Y at or beyond this is parked/off-screen and never hits
- `Lives_Init`, 3'd3: lives after reset (1..7)
- `Invuln_Frames`, 8'd60: post-hit invulnerability length in frames (only with `COWBOY_HIT_INVULN_EN`)
- `Clk` in 1: 50 MHz system clock
- `Reset` in 1: synchronous, active-high; one clock; reset is synchronous and active-high
- `frame_clk` in 1: ~60 Hz frame strobe (vs from VGA controller)
- `LaserX`, `LaserY` in 10 each: laser top-left, unsigned
- `CowboyX`, `CowboyY` in 10 each: cowboy top-left, unsigned
- `GG` out 1: game over, sticky until `Reset`
- `Lives` out 3: remaining lives
- `HitPulse` out 1: one-`Clk` pulse per counted hit (sound/score)
- `Hit_Flash` out 1: sprite blink enable for the renderer

## Operation
- Frame edge detection:
  - `frame_clk_delayed <= frame_clk`.
  - `frame_clk_rising_edge <= frame_clk & ~frame_clk_delayed`.
  - All game logic advances only on cycles where `frame_clk_rising_edge` is 1.
- Overlap is combinational, evaluated in 11-bit unsigned (zero-extended) so sums cannot wrap. `Overlap` is true when all of the following hold:
  - `LaserY < Screen_Y_Max`
  - `LaserX < CowboyX+CowboyW` and `CowboyX < LaserX+LaserW`
  - `LaserY < CowboyY+CowboyH` and `CowboyY < LaserY+LaserH`
  - Edges that only touch do not overlap.
- Re-arm flag `Armed`:
  - Reset value is 1.
  - A counted hit clears it.
  - It sets again on the first frame edge with `Overlap`=0.
  - A hit is counted only when `Armed`=1, so one laser pass costs at most one life.
- States `{Play, Cooldown, Dead}`, evaluated on frame edge only:
  - **Play**: if `Overlap` and `Armed`, then `Lives` ← `Lives`−1, pulse `HitPulse`, clear `Armed`. If `Lives` was 1: go to Dead. Otherwise go to Cooldown with `Icount` ← `Invuln_Frames`.
  - **Cooldown**: hits ignored; `Armed` still updates. `Icount` ← `Icount`−1. When `Icount` is 1, go to Play. If `Invuln_Frames`=0, Cooldown lasts exactly one frame.
  - **Dead**: `GG`=1 and `Lives`=0. No exit except `Reset`. `Hit_Flash`=0.
- `Hit_Flash` = (state==Cooldown) & `Icount[2]`: an 8-frame blink.
- `Lives` never underflows; the hit that leaves 0 lives enters Dead.
- `Reset` mid-Cooldown or in Dead returns everything to reset values next cycle. It has priority over a coincident frame edge.

## Timing
- Reset values: `GG`=0, `Lives`=`Lives_Init`, `HitPulse`=0, `Hit_Flash`=0, state=Play, `Icount`=0, `Armed`=1, `frame_clk_delayed`=0, `frame_clk_rising_edge`=0.
- Cycle counting:
  - Cycle n: `frame_clk` is first seen high by `Clk`.
  - Cycle n+1: `frame_clk_rising_edge`=1; positions are sampled here.
  - Cycle n+2: state, `Lives`, `GG` and `Armed` are updated; `HitPulse`=1 for this cycle only.
- Positions need only be stable on the sampling cycle. Upstream position updates landing in the same cycle use the pre-update register values.
- `GG` is registered and glitch-free. It rises in the same cycle `Lives` reaches 0.
- At most one hit per frame.

## Configuration
- `COWBOY_HIT_INVULN_EN` defined:
  - Cooldown state, `Icount` and `Hit_Flash` exist as described.
- Not defined:
  - Play goes straight back to Play after a non-fatal hit; only the `Armed` rule limits repeat hits.
  - `Icount` is removed, `Hit_Flash` is tied 0, and the `Invuln_Frames` parameter is unused.
  - All other behaviour is identical.

## Test plan
- **Reset defaults:** assert `Reset` 2 cycles, then release → `Lives`=3, `GG`=0, `HitPulse`=0, `Hit_Flash`=0.
- **Single hit:** Laser (100,200), Cowboy (90,190), one frame edge → `HitPulse` for 1 cycle at n+2, `Lives`=2. Holding overlap 5 more frames → `Lives` stays 2, with or without the macro.
- **Touching edges and parked laser:**
  - Laser X=122, Cowboy X=90, W=32 (touching) → no hit.
  - Laser Y=500, X overlapping → no hit.
  - Laser (1020,200), Cowboy (1000,190) → 11-bit math gives a hit; no wrap false negatives.
- **Invulnerability (macro on, `Invuln_Frames`=4):**
  - Hit, then laser leaves for 1 frame and returns overlapping on frames 2–3 → no decrement.
  - Overlap on the 5th edge after the hit → `Lives` decrements.
  - `Hit_Flash` follows `Icount[2]`.
- **Game over:** three separated hits → `Lives`=0 and `GG`=1 on the third hit's n+2 cycle. Further overlaps and frame edges leave both unchanged; `Reset` restores `Lives`=3, `GG`=0.
- **Reset priority:** assert `Reset` in the same cycle as `frame_clk_rising_edge` with overlap → no `HitPulse`, `Lives`=`Lives_Init`.
